// File: rtl/vga_hsync_monitor.sv
// vga_hsync_monitor: measures hsync/DE line timing against expected
// parameters, tracks pixel index and declares lock after matching lines.
module vga_hsync_monitor #(
  parameter int SYNC_TIME    = 96,
  parameter int DISPLAY_TIME = 640,
  parameter int TOTAL        = 800,
  parameter int LOCK_LINES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_25Mhz,
  input  logic        horizontal_sync,
  input  logic        horizontal_display_sync,
  output logic [9:0]  pixel_x,
  output logic        pixel_valid,
  output logic        line_start,
  output logic [10:0] sync_width,
  output logic [10:0] line_total,
  output logic [10:0] display_width,
  output logic        locked,
  output logic        timing_error
);

  localparam logic [10:0] SYNC_W = 11'(SYNC_TIME);
  localparam logic [10:0] DISP_W = 11'(DISPLAY_TIME);
  localparam logic [10:0] TOT_W  = 11'(TOTAL);
  localparam logic [3:0]  LOCK_W = 4'(LOCK_LINES);
  localparam logic [10:0] T_MAX  = 11'h7FF;
  localparam logic [10:0] T_PRE  = 11'h7FE;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        hs_prev;
  logic [10:0] tick;
  logic [10:0] de_cnt;
  logic [3:0]  match_cnt;
  logic [3:0]  match_cnt_d;
  logic        sync_seen;
  logic        locked_d;
  logic        err_d;

  logic strobe;
  logic de;
  logic fall;
  logic rise;
  logic match;
  logic timeout;

  assign strobe  = clk_25Mhz;
  assign de      = horizontal_display_sync;
  assign fall    = strobe & hs_prev & ~horizontal_sync;
  assign rise    = strobe & ~hs_prev & horizontal_sync;
  assign match   = sync_seen
                 && (sync_width == SYNC_W)
                 && (tick == TOT_W)
                 && (de_cnt == DISP_W);
  // tick is about to reach its ceiling with no edge in sight
  assign timeout = strobe & ~fall & (tick == T_PRE);

  // lock FSM: next state, lock flag and error pulse
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt;
    locked_d    = locked;
    err_d       = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (fall) begin
          state_d     = MEASURE;
          match_cnt_d = 4'd0;
        end
      end
      MEASURE: begin
        if (fall) begin
          if (match) begin
            match_cnt_d = match_cnt + 4'd1;
            if (match_cnt_d == LOCK_W) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = 4'd0;
            err_d       = 1'b1;
          end
        end else if (timeout) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      LOCKED: begin
        if (fall) begin
          if (!match) begin
            state_d     = MEASURE;
            locked_d    = 1'b0;
            match_cnt_d = 4'd0;
            err_d       = 1'b1;
          end
        end else if (timeout) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    endcase
  end

  // FSM state, lock flag and one-clk pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      match_cnt    <= 4'd0;
      locked       <= 1'b0;
      line_start   <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt    <= match_cnt_d;
      locked       <= locked_d;
      line_start   <= fall;
      timing_error <= err_d;
    end
  end

  // edge history and saturating tick / DE counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev <= 1'b1;
      tick    <= 11'd0;
      de_cnt  <= 11'd0;
    end else if (strobe) begin
      hs_prev <= horizontal_sync;
      if (fall) begin
        tick   <= 11'd1;
        de_cnt <= {10'd0, de};
      end else begin
        if (tick != T_MAX) begin
          tick <= tick + 11'd1;
        end
        if (de) begin
          de_cnt <= de_cnt + 11'd1;
        end
      end
    end
  end

  // measurement captures, held through SEARCH
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_seen     <= 1'b0;
      sync_width    <= 11'd0;
      line_total    <= 11'd0;
      display_width <= 11'd0;
    end else if (strobe) begin
      if (rise) begin
        sync_width <= tick;
        sync_seen  <= 1'b1;
      end
      if (fall) begin
        sync_seen <= 1'b0;
        if (state_q != SEARCH) begin
          line_total    <= tick;
          display_width <= de_cnt;
        end
      end
    end
  end

  // active-pixel index; a DE pixel on the falling edge starts the new line
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= 10'd0;
      pixel_valid <= 1'b0;
    end else if (strobe) begin
      pixel_valid <= de;
      if (de) begin
        pixel_x <= fall ? 10'd0 : de_cnt[9:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_hsync_monitor.sv
// tb_vga_hsync_monitor: line-level reference model of hsync timing
// checked strobe-by-strobe against vga_hsync_monitor.
module tb_vga_hsync_monitor;

  localparam int SYNC  = 96;
  localparam int DISP  = 640;
  localparam int TOT   = 800;
  localparam int LOCKN = 4;
  localparam int BP    = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_25Mhz;
  logic        horizontal_sync;
  logic        horizontal_display_sync;
  logic [9:0]  pixel_x;
  logic        pixel_valid;
  logic        line_start;
  logic [10:0] sync_width;
  logic [10:0] line_total;
  logic [10:0] display_width;
  logic        locked;
  logic        timing_error;

  always #5 clk = ~clk;

  vga_hsync_monitor #(
    .SYNC_TIME(SYNC),
    .DISPLAY_TIME(DISP),
    .TOTAL(TOT),
    .LOCK_LINES(LOCKN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_25Mhz(clk_25Mhz),
    .horizontal_sync(horizontal_sync),
    .horizontal_display_sync(horizontal_display_sync),
    .pixel_x(pixel_x),
    .pixel_valid(pixel_valid),
    .line_start(line_start),
    .sync_width(sync_width),
    .line_total(line_total),
    .display_width(display_width),
    .locked(locked),
    .timing_error(timing_error)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: strobe indices since the last falling edge
  int idx = 0;
  int anchor = 0;
  int de_line = 0;
  bit m_prev, m_search, m_locked, m_seen;
  int m_run;
  int e_px, e_pv, e_sw, e_lt, e_dw, e_ls, e_err;

  int err_cnt = 0;
  int lock_seen = 0;
  bit rand_gap = 1'b0;
  int px_first, px_last, pv_cnt, bad_pv;

  task automatic model_reset();
    m_prev   = 1'b1;
    m_search = 1'b1;
    m_locked = 1'b0;
    m_seen   = 1'b0;
    m_run    = 0;
    de_line  = 0;
    anchor   = idx;
    e_px = 0; e_pv = 0; e_sw = 0; e_lt = 0;
    e_dw = 0; e_ls = 0; e_err = 0;
  endtask

  task automatic model_step(bit hs, bit de);
    bit fall, rise, match;
    int t;
    fall = m_prev && !hs;
    rise = !m_prev && hs;
    t = idx - anchor;
    if (t > 2047) t = 2047;
    e_ls = int'(fall);
    e_err = 0;
    if (de) begin
      e_pv = 1;
      e_px = fall ? 0 : (de_line % 1024);
    end else begin
      e_pv = 0;
    end
    if (rise) begin
      e_sw = t;
      m_seen = 1'b1;
    end
    if (fall) begin
      match = m_seen && e_sw == SYNC && t == TOT && de_line == DISP;
      m_seen = 1'b0;
      if (m_search) begin
        m_search = 1'b0;
        m_run = 0;
      end else begin
        e_lt = t;
        e_dw = de_line;
        if (match) begin
          if (!m_locked) begin
            m_run++;
            if (m_run == LOCKN) m_locked = 1'b1;
          end
        end else begin
          e_err = 1;
          m_locked = 1'b0;
          m_run = 0;
        end
      end
      anchor = idx;
      de_line = int'(de);
    end else begin
      if (!m_search && t == 2046) begin
        m_search = 1'b1;
        m_locked = 1'b0;
        e_err = 1;
      end
      if (de) de_line++;
    end
    m_prev = hs;
    idx++;
  endtask

  task automatic strobe(bit hs, bit de);
    int g;
    g = rand_gap ? int'($urandom_range(1, 3)) : 4;
    @(negedge clk);
    horizontal_sync = hs;
    horizontal_display_sync = de;
    clk_25Mhz = 1'b1;
    @(posedge clk);
    #1;
    model_step(hs, de);
    chk("pixel_x", 32'(pixel_x), e_px);
    chk("pixel_valid", 32'(pixel_valid), e_pv);
    chk("line_start", 32'(line_start), e_ls);
    chk("sync_width", 32'(sync_width), e_sw);
    chk("line_total", 32'(line_total), e_lt);
    chk("display_width", 32'(display_width), e_dw);
    chk("locked", 32'(locked), int'(m_locked));
    chk("timing_error", 32'(timing_error), e_err);
    if (timing_error) err_cnt++;
    if (locked) lock_seen++;
    if (pixel_valid) begin
      if (pv_cnt == 0) px_first = int'(pixel_x);
      px_last = int'(pixel_x);
      pv_cnt++;
    end
    if (!de && pixel_valid) bad_pv++;
    for (int i = 1; i < g; i++) begin
      @(negedge clk);
      clk_25Mhz = 1'b0;
      @(posedge clk);
      #1;
      if (i == 1) begin
        chk("line_start_len", 32'(line_start), 0);
        chk("timing_error_len", 32'(timing_error), 0);
      end
    end
  endtask

  task automatic line(int sw, int disp, int tot, int n);
    bit hs, de;
    px_first = -1; px_last = -1;
    pv_cnt = 0; bad_pv = 0;
    for (int i = 0; i < n; i++) begin
      hs = (i >= sw);
      de = (i >= sw + BP) && (i < sw + BP + disp);
      strobe(hs, de);
    end
    if (n < tot) begin
      @(negedge clk);
      clk_25Mhz = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clk_25Mhz = 1'($urandom_range(0, 1));
    horizontal_sync = 1'($urandom_range(0, 1));
    horizontal_display_sync = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_pixel_x", 32'(pixel_x), 0);
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_sync_width", 32'(sync_width), 0);
    chk("rst_line_total", 32'(line_total), 0);
    chk("rst_display_width", 32'(display_width), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timing_error", 32'(timing_error), 0);
    @(negedge clk);
    rst = 1'b0;
    clk_25Mhz = 1'b0;
    horizontal_sync = 1'b1;
    horizontal_display_sync = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stop, sw, dp, tt;
    rst = 1'b1;
    clk_25Mhz = 1'b0;
    horizontal_sync = 1'b1;
    horizontal_display_sync = 1'b0;
    do_reset();

    // standard 640x480 timing, strobe every 4th clk
    rand_gap = 1'b0;
    err_cnt = 0;
    for (int l = 0; l < 4; l++) line(SYNC, DISP, TOT, TOT);
    chk("lock_early", 32'(locked), 0);
    line(SYNC, DISP, TOT, TOT);
    line(SYNC, DISP, TOT, TOT);
    chk("lock_std", 32'(locked), 1);
    chk("sw_std", 32'(sync_width), 96);
    chk("lt_std", 32'(line_total), 800);
    chk("dw_std", 32'(display_width), 640);
    chk("err_std", err_cnt, 0);
    chk("px_first", px_first, 0);
    chk("px_last", px_last, 639);
    chk("px_count", pv_cnt, 640);
    chk("pv_porch", bad_pv, 0);

    // one long line while locked
    rand_gap = 1'b1;
    err_cnt = 0;
    line(SYNC, DISP, 801, 801);
    line(SYNC, DISP, TOT, TOT);
    chk("lt_801", 32'(line_total), 801);
    chk("err_801", err_cnt, 1);
    chk("unlock_801", 32'(locked), 0);
    for (int l = 0; l < 4; l++) line(SYNC, DISP, TOT, TOT);
    chk("relock_801", 32'(locked), 1);

    // hsync stuck high: timeout
    err_cnt = 0;
    repeat (2100) strobe(1'b1, 1'b0);
    chk("err_tmo", err_cnt, 1);
    chk("unlock_tmo", 32'(locked), 0);
    for (int l = 0; l < 4; l++) line(SYNC, DISP, TOT, TOT);
    chk("lock_tmo_early", 32'(locked), 0);
    line(SYNC, DISP, TOT, TOT);
    chk("relock_tmo", 32'(locked), 1);
    chk("err_tmo_total", err_cnt, 1);

    // reset mid-line while locked
    stop = int'($urandom_range(100, 700));
    line(SYNC, DISP, TOT, stop);
    do_reset();
    line(SYNC, DISP, TOT, TOT);
    chk("no_capture_lt", 32'(line_total), 0);
    chk("no_capture_dw", 32'(display_width), 0);
    line(SYNC, DISP, TOT, TOT);
    chk("capture_lt", 32'(line_total), 800);

    // short sync pulse every line
    do_reset();
    err_cnt = 0;
    lock_seen = 0;
    for (int l = 0; l < 7; l++) line(95, DISP, TOT, TOT);
    chk("sw_95", 32'(sync_width), 95);
    chk("err_95", err_cnt, 6);
    chk("lock_95", lock_seen, 0);

    // random line timings
    do_reset();
    for (int l = 0; l < 6; l++) begin
      if ($urandom_range(0, 9) < 6) begin
        sw = SYNC; dp = DISP; tt = TOT;
      end else begin
        sw = int'($urandom_range(94, 98));
        dp = int'($urandom_range(638, 642));
        tt = int'($urandom_range(798, 802));
      end
      line(sw, dp, tt, tt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vga_hsync_monitor.md
VGA_HSYNC_MONITOR -- requirements
Module: vga_hsync_monitor

Interface
REQ-001 The block SHALL have parameter SYNC_TIME, default 96, giving the expected hsync low width in pixel strobes.
REQ-002 The block SHALL have parameter DISPLAY_TIME, default 640, giving the expected active pixels per line.
REQ-003 The block SHALL have parameter TOTAL, default 800, giving the expected strobes from one hsync falling edge to the next.
REQ-004 The block SHALL have parameter LOCK_LINES, default 4, giving the consecutive matching lines required for lock (range 1-15).
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset, on these ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have these remaining ports:
- clk_25Mhz  input  1  pixel strobe; 1-clk-wide enable, all sampling gated by it.
- horizontal_sync  input  1  incoming hsync, active low.
- horizontal_display_sync  input  1  incoming display enable, active high.
- pixel_x  output  10  index of the current active pixel.
- pixel_valid  output  1  current strobe was an active pixel.
- line_start  output  1  1-clk pulse on a detected hsync falling edge.
- sync_width  output  11  last measured hsync low width.
- line_total  output  11  last measured line period.
- display_width  output  11  last measured active-pixel count.
- locked  output  1  timing matches the parameters.
- timing_error  output  1  1-clk pulse on a mismatch or timeout.

Function
REQ-007 A "strobe" SHALL be a posedge clk with clk_25Mhz=1; all registers except pulse outputs SHALL hold their value on non-strobe cycles.
REQ-008 The block SHALL register the previous sampled hsync (hs_prev) on every strobe; a falling edge SHALL be hs_prev=1 and horizontal_sync=0, and a rising edge SHALL be hs_prev=0 and horizontal_sync=1.
REQ-009 The tick counter (11 b) SHALL load 1 on a falling-edge strobe and otherwise increment on each strobe, saturating at 2047.
REQ-010 On a rising-edge strobe, the block SHALL capture tick counter (pre-update) into sync_width and set the internal flag sync_seen; sync_seen SHALL clear on every falling edge.
REQ-011 On a falling-edge strobe (not the first after SEARCH), the block SHALL capture tick counter (pre-update) into line_total and de counter (pre-update) into display_width.
REQ-012 The de counter (11 b) SHALL load 1 if horizontal_display_sync=1 else 0 on a falling-edge strobe, and otherwise increment on strobes with horizontal_display_sync=1.
REQ-013 On a strobe with horizontal_display_sync=1, the block SHALL set pixel_valid=1 and pixel_x=de counter value before update, truncated to 10 b (0 on the first active pixel when the falling edge is not coincident).
REQ-014 On a strobe with horizontal_display_sync=0, the block SHALL set pixel_valid=0 and hold pixel_x.
REQ-015 line_start SHALL be 1 for exactly the clk cycle following each falling-edge strobe, in every state.
REQ-016 The FSM SHALL have the states SEARCH, MEASURE and LOCKED, and SHALL enter SEARCH on reset.
REQ-017 In SEARCH, the first falling edge SHALL move the FSM to MEASURE with no capture or compare, and SHALL clear match_cnt.
REQ-018 A line SHALL match when sync_seen=1, sync_width=SYNC_TIME, captured total=TOTAL and captured display=DISPLAY_TIME, with the comparison evaluated at the falling edge on the values being captured.
REQ-019 In MEASURE, a match SHALL increment match_cnt, and on reaching LOCK_LINES the FSM SHALL go to LOCKED and set locked=1 on the same update.
REQ-020 In MEASURE, a mismatch SHALL clear match_cnt and pulse timing_error, and the FSM SHALL stay in MEASURE.
REQ-021 In LOCKED, a match SHALL hold the state.
REQ-022 In LOCKED, a mismatch SHALL move the FSM to MEASURE, clear locked and match_cnt, and pulse timing_error.
REQ-023 Timeout: in MEASURE or LOCKED, if the tick counter reaches 2047, the FSM SHALL go to SEARCH, clear locked, and pulse timing_error once.
REQ-024 Captured measurement outputs SHALL hold their last values through SEARCH.
REQ-025 A falling and a rising edge cannot coincide on one strobe; a falling edge with de=1 on the same strobe SHALL count that pixel in the new line.

Reset
REQ-026 When rst=1 at posedge clk (regardless of clk_25Mhz), the block SHALL set state=SEARCH, hs_prev=1, tick and de counters=0, match_cnt=0 and sync_seen=0.
REQ-027 The same reset SHALL set pixel_x=0, pixel_valid=0, line_start=0, sync_width=0, line_total=0, display_width=0, locked=0 and timing_error=0.
REQ-028 rst asserted mid-line or while LOCKED SHALL take effect in the same cycle, and the next line SHALL be treated as a fresh SEARCH.

Verification
REQ-029 The bench SHALL drive standard 640x480 timing (strobe every 4th clk, hsync low 96, DE 640 of 800) for 6 lines and SHALL see locked=1 after the 5th falling edge, with sync_width=96, line_total=800, display_width=640 and no timing_error.
REQ-030 The bench SHALL check that, within an active line, pixel_x runs 0..639 with pixel_valid=1 and that pixel_valid=0 during porches and sync.
REQ-031 The bench SHALL, while locked, drive one line of 801 strobes and SHALL see line_total=801, a timing_error pulse and locked=0, then locked=1 again after 4 further good lines.
REQ-032 The bench SHALL, while locked, hold hsync high for 2100 strobes and SHALL see one timing_error pulse at tick 2047 with state SEARCH, then re-lock after 1+4 good edges.
REQ-033 The bench SHALL drive an hsync low width of 95 and SHALL see sync_width=95, a timing_error pulse on every line and locked never set.
REQ-034 The bench SHALL assert rst for 1 clk mid-line while locked and SHALL see all outputs zero next cycle, with the first subsequent falling edge causing no capture.
